uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter peripheral on the shared data bus, a sibling of the LED peripheral and a consumer of CPU store traffic.
- CPU word writes to TXDATA push bytes into a small TX FIFO.
- A baud-rate divider and a framing state machine serialise each byte onto uart_tx as 8N1, LSB first.
- STATUS and BAUDDIV registers are readable back over the same bus.

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 50 +++++
 rtl/uart_tx_periph.sv | 153 +++++++++++++++
 tb/tb_uart_tx_periph.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants and FSM state type for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_tx_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_PARITY = 4;
  localparam int ST_COUNT  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; head is visible on rdata, simultaneous push/pop
// is accepted even when full.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/BAUDDIV window, byte FIFO,
// 8N1 serialiser (8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_periph
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [31:0] data_bus_data,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode,
  output logic        uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]  off;
  logic        win, hit, wr_en, rd_en, push, pop;
  logic [7:0]  fifo_rdata;
  logic        full, empty;
  logic [CW-1:0] count;
  logic [15:0] baud_div, div_latched, timer;
  logic        overflow;
  logic [2:0]  idx;
  logic [7:0]  shift;
  state_t      state;
  logic [31:0] status, rdata;
  logic        unused_bits;

  assign off   = data_bus_addr[3:0];
  assign win   = data_bus_addr[31:4] == BASE_ADDR[31:4];
  assign hit   = win && (off == OFF_TXDATA || off == OFF_STATUS || off == OFF_BAUDDIV);
  assign wr_en = reset && hit && data_bus_mode == MODE_WRITE;
  // Unmapped offsets inside the window still answer reads, with zero.
  assign rd_en = reset && win && data_bus_mode == MODE_READ;
  assign push  = wr_en && off == OFF_TXDATA;
  assign pop   = reset && !empty && (state == S_IDLE || (state == S_STOP && timer == '0));
  assign unused_bits = ^data_bus_data[31:16];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (data_bus_data[7:0]),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = state != S_IDLE;
    status[ST_OVF]   = overflow;
    status[ST_COUNT +: CW] = count;
`ifdef UART_TX_PARITY_EN
    status[ST_PARITY] = 1'b1;
`endif
  end

  always_comb begin
    rdata = '0;
    if (hit && off == OFF_STATUS)  rdata = status;
    if (hit && off == OFF_BAUDDIV) rdata = {16'h0, baud_div};
  end

  assign data_bus_data = rd_en ? rdata : 32'bz;

  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_div <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_en && off == OFF_BAUDDIV) baud_div <= data_bus_data[15:0];
      if (wr_en && off == OFF_STATUS)  overflow <= 1'b0;
      else if (push && full && !pop)   overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      uart_tx     <= 1'b1;
      timer       <= '0;
      idx         <= '0;
      shift       <= '0;
      div_latched <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          shift       <= fifo_rdata;
          div_latched <= baud_div;
          timer       <= baud_div;
          state       <= S_START;
          uart_tx     <= 1'b0;
        end
        S_START: if (timer != '0) timer <= timer - 1'b1;
        else begin
          state   <= S_DATA;
          idx     <= '0;
          timer   <= div_latched;
          uart_tx <= shift[0];
        end
        S_DATA: if (timer != '0) timer <= timer - 1'b1;
        else if (idx == 3'd7) begin
          timer <= div_latched;
`ifdef UART_TX_PARITY_EN
          state   <= S_PARITY;
          uart_tx <= ^shift;
`else
          state   <= S_STOP;
          uart_tx <= 1'b1;
`endif
        end else begin
          idx     <= idx + 3'd1;
          timer   <= div_latched;
          uart_tx <= shift[idx + 3'd1];
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (timer != '0) timer <= timer - 1'b1;
        else begin
          state   <= S_STOP;
          timer   <= div_latched;
          uart_tx <= 1'b1;
        end
`endif
        // A queued byte at the last stop edge starts the next frame directly.
        S_STOP: if (timer != '0) timer <= timer - 1'b1;
        else if (!empty) begin
          shift       <= fifo_rdata;
          div_latched <= baud_div;
          timer       <= baud_div;
          state       <= S_START;
          uart_tx     <= 1'b0;
        end else begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: directed scenarios plus random traffic against a
// line-level reference model (expected bit stream built per queued byte).
module tb_uart_tx_periph;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int          FL    = 11;
  localparam logic [31:0] PAR   = 32'h10;
`else
  localparam int          FL    = 10;
  localparam logic [31:0] PAR   = 32'h0;
`endif

  logic        clk = 0, reset = 0;
  logic [31:0] addr = '0, drv = '0;
  logic [1:0]  mode = '0;
  logic        oe = 0;
  logic        uart_tx;
  wire  [31:0] bus;

  assign bus = oe ? drv : 32'bz;

  uart_tx_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_bus_data (bus),
    .data_bus_addr (addr),
    .data_bus_mode (mode),
    .uart_tx       (uart_tx)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: byte queue plus queue of per-cycle line levels.
  byte unsigned mq[$];
  bit           line[$];
  int unsigned  m_div = 433;
  bit           m_ovf = 0, m_busy = 0, m_tx = 1;

  function automatic logic frame_bit(logic [7:0] b, int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    logic [7:0] b;
    if (!reset) begin
      mq.delete(); line.delete();
      m_div = 433; m_ovf = 0; m_busy = 0; m_tx = 1;
    end else begin
      if (line.size() == 0 && mq.size() != 0) begin
        b = mq.pop_front();
        for (int i = 0; i < FL; i++)
          for (int c = 0; c <= int'(m_div); c++) line.push_back(frame_bit(b, i));
      end
      if (line.size() != 0) begin m_tx = line.pop_front(); m_busy = 1; end
      else begin m_tx = 1; m_busy = 0; end
      if (mode == 2'b10 && addr[31:4] == BASE[31:4]) begin
        case (addr[3:0])
          4'h0: if (mq.size() < DEPTH) mq.push_back(drv[7:0]); else m_ovf = 1;
          4'h4: m_ovf = 0;
          4'h8: m_div = drv[15:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = PAR;
    s[0] = mq.size() == DEPTH;
    s[1] = mq.size() == 0;
    s[2] = m_busy;
    s[3] = m_ovf;
    s[11:8] = 4'(mq.size());
    return s;
  endfunction

  bit mon = 0;
  always @(negedge clk) if (mon) chk("tx_line", 32'(uart_tx), 32'(m_tx));

  task automatic wr(logic [3:0] off, logic [31:0] d);
    addr = BASE | 32'(off); drv = d; oe = 1; mode = 2'b10;
    @(negedge clk);
    mode = 2'b00; oe = 0;
  endtask

  task automatic rd(logic [3:0] off, output logic [31:0] d);
    addr = BASE | 32'(off); oe = 0; mode = 2'b01;
    #1 d = bus;
    @(negedge clk);
    mode = 2'b00;
  endtask

  task automatic chk_status(string tag);
    logic [31:0] e, d;
    e = m_status();
    rd(4'h4, d);
    chk(tag, d, e);
  endtask

  // Samples the line at the current negedge onward against literal frames.
  task automatic chk_frames(logic [7:0] b0, logic [7:0] b1, int n, int d, string tag);
    logic [7:0] b;
    for (int f = 0; f < n; f++) begin
      b = (f == 0) ? b0 : b1;
      for (int i = 0; i < FL; i++)
        for (int c = 0; c <= d; c++) begin
          chk(tag, 32'(uart_tx), 32'(frame_bit(b, i)));
          @(negedge clk);
        end
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((line.size() != 0 || mq.size() != 0 || m_busy) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("drain_bound", 32'(n < budget), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge clk);
    reset = 1; mon = 1;

    chk("rst_tx", 32'(uart_tx), 32'd1);
    rd(4'h4, d); chk("rst_status", d, 32'h2 | PAR);
    rd(4'h8, d); chk("rst_baud", d, 32'd433);
    rd(4'h0, d); chk("txdata_rd0", d, 32'd0);

    // Single frame A5 at 4 cycles per bit.
    wr(4'h8, 32'd3);
    rd(4'h8, d); chk("baud_rb", d, 32'd3);
    wr(4'h0, 32'hA5);
    @(negedge clk);
    chk_frames(8'hA5, 8'h00, 1, 3, "frame_a5");
    drain(100);
    wr(4'h0, 32'h3C);
    repeat (3) @(negedge clk);
    rd(4'h4, d); chk("busy_empty", d, 32'h6 | PAR);
    drain(100);

    // Fill to full during a 1-cycle-per-bit frame; ninth queued write drops.
    wr(4'h8, 32'd0);
    wr(4'h0, 32'h11);
    for (int i = 0; i < 9; i++) wr(4'h0, 32'(8'h20 + i));
    rd(4'h4, d); chk("full_ovf", d, 32'h80D | PAR);
    wr(4'h4, 32'd0);
    rd(4'h4, d); chk("ovf_clear", 32'(d[3]), 32'd0);
    drain(200);

    // Back-to-back frames with no idle gap.
    wr(4'h8, 32'd1);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'hFF);
    chk_frames(8'h00, 8'hFF, 2, 1, "b2b");
    drain(100);

`ifdef UART_TX_PARITY_EN
    wr(4'h0, 32'h07);
    @(negedge clk);
    chk_frames(8'h07, 8'h00, 1, 1, "parity_07");
    rd(4'h4, d); chk("parity_flag", 32'(d[4]), 32'd1);
    drain(100);
`endif

    // Reset mid-DATA.
    wr(4'h8, 32'd3);
    wr(4'h0, 32'h5A);
    repeat (12) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("midrst_tx", 32'(uart_tx), 32'd1);
    reset = 1;
    rd(4'h4, d); chk("midrst_status", d, 32'h2 | PAR);
    rd(4'h8, d); chk("midrst_baud", d, 32'd433);
    repeat (60) @(negedge clk);

    // Random traffic against the model.
    wr(4'h8, 32'($urandom_range(0, 3)));
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: wr(4'h0, 32'($urandom_range(0, 255)));
        5: wr(4'h8, 32'($urandom_range(0, 3)));
        6: chk_status("rnd_status");
        7: begin rd(4'h8, d); chk("rnd_baud", d, 32'(m_div)); end
        8: wr(4'h4, 32'd0);
        default: repeat ($urandom_range(0, 15)) @(negedge clk);
      endcase
    end
    drain(2000);
    chk_status("final_status");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
